factor_search_seq: RTL and testbench
====================================

// Module: factor_search_seq
// PURPOSE
// Sequential producer of factor candidates for the factorization product checker.
// - Accepts a 2W-bit product y and enumerates factor pairs (x1, x2).
// - Forms each product with a W-cycle shift-add multiplier.
// - Applies the checker's acceptance rule: x1*x2 == y, and neither factor equal to 1.
// - Reports the first accepting pair, or not-found, over a valid/ready handshake.
// PARAMETERS
// W      2   factor width in bits; product width is 2*W
// PORTS
// clk          in   1    clock, rising edge
// rst          in   1    asynchronous, active-high reset
// in_valid     in   1    y is valid
// in_ready     out  1    block can accept y (high only in IDLE)
// y            in   2W   product to factor, unsigned
// out_valid    out  1    result is valid
// out_ready    in   1    consumer accepts the result
// found        out  1    1 = accepting pair found, 0 = search exhausted
// x1_out       out  W    first factor (0 when found=0)
// x2_out       out  W    second factor (0 when found=0)
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=IDLE; in_ready=1; out_valid=0; found=0; x1_out=0; x2_out=0.
//   - Multiplier accumulator, counters and the y register are cleared.
//   - Reset mid-search aborts the search immediately; no result is produced.
// - Handshake rules:
//   - Input transfer occurs on a cycle with in_valid & in_ready.
//   - Output transfer occurs on a cycle with out_valid & out_ready.
//   - in_valid is ignored while busy; y is registered at accept and is stable for the whole search.
// - FSM states and transitions:
//   - IDLE -> MUL on input accept: latch y; x1=0, x2=0; acc=0; bit counter=0.
//   - MUL, W cycles, LSB first: each cycle, if bit i of x2 is set, acc += x1<<i.
//     acc is 2W bits and never overflows.
//   - MUL -> CHK after W cycles.
//   - CHK (1 cycle), hit = (acc==y) & (x1!=1) & (x2!=1):
//     - hit: load x1_out/x2_out, found=1, go to DONE.
//     - miss, candidates remaining: advance to the next pair, clear acc, go to MUL.
//     - miss, last pair: found=0, x1_out=x2_out=0, go to DONE.
//   - DONE: out_valid=1; outputs held stable until out_ready; then out_valid=0 and go to IDLE.
//   - in_ready rises in the cycle after the output transfer.
// - Enumeration order:
//   - x2 is the inner loop, x1 the outer loop; both run 0..2^W-1 ascending.
//   - Pairs with x1==1 or x2==1 are skipped: they are never multiplied and cost 0 cycles.
//   - Wrap-around: x2 at 2^W-1 wraps to 0 (or the symmetric start) and x1 increments.
//     x1 at 2^W-1 with the inner loop finished is the last pair.
// - Latency:
//   - With the input accepted in cycle k and N pairs tried, out_valid is first high in cycle k+N*(W+1)+1.
// - y=0: pair (0,0) hits first, so found=1 with x1_out=0, x2_out=0.
// - Simultaneous in_valid with DONE/out_ready: not accepted in that cycle (in_ready=0).
// CONFIGURATION
// - FACTOR_SEARCH_SYMM_EN defined:
//   - The inner loop starts at x2=x1, so only pairs with x2>=x1 are tried and x1_out<=x2_out is guaranteed.
//   - W=2 exhaustive search: 6 pairs, 18 cycles of search.
// - Not defined:
//   - All (x1, x2) pairs are tried.
//   - W=2 exhaustive search: 9 pairs, 27 cycles of search.
// - In both modes the first hit in enumeration order is the one reported.
// TESTING (W=2)
// 1. Accept y=4'd6, out_ready=1 -> found=1, x1_out=2, x2_out=3 (both modes).
// 2. Accept y=4'd9 -> found=1, x1_out=3, x2_out=3.
// 3. Accept y=4'd5 -> found=0, x1_out=x2_out=0.
//    out_valid high at k+28 without FACTOR_SEARCH_SYMM_EN, at k+19 with it.
// 4. Accept y=4'd2 (needs factor 1) -> found=0: trivial factors are rejected.
// 5. Accept y=4'd4, hold out_ready=0 for 5 cycles ->
//    - out_valid, found=1, x1_out=2, x2_out=2 held stable throughout;
//    - in_ready=0 during the stall;
//    - in_valid pulses during the stall are ignored.
// 6. Assert rst for 1 cycle mid-MUL during y=4'd9 ->
//    - all outputs are at reset values while rst is high, in_ready=1 after rst falls;
//    - a new y=4'd0 then returns found=1, x1_out=0, x2_out=0.

Source files
------------

// File: rtl/factor_search_seq.sv
// Sequential factor-pair search: shift-add multiplies each candidate pair and reports the first non-trivial hit.
// Optional macro FACTOR_SEARCH_SYMM_EN restricts the inner loop to x2 >= x1.
module factor_search_seq #(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           found,
  output logic [W-1:0]   x1_out,
  output logic [W-1:0]   x2_out
);

  // Handshake: a transfer happens on any rising edge where valid & ready are both high;
  // in_ready is high only in IDLE, and results are held stable in DONE until out_ready.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] XMAX = '1;
  localparam logic [W-1:0] XONE = W'(1);

  typedef enum logic [1:0] {IDLE, MUL, CHK, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] y_q;
  logic [2*W-1:0] acc;
  logic [W-1:0]   x1;
  logic [W-1:0]   x2;
  logic [CW-1:0]  bit_cnt;

  logic [W-1:0]   nx1;
  logic [W-1:0]   nx2;
  logic           last_pair;
  logic           hit;
  logic [2*W-1:0] partial;

  // Successor in the candidate sequence 0, 2, 3, ... : the trivial factor 1 is never visited.
  function automatic logic [W-1:0] step(input logic [W-1:0] v);
    return (v == '0) ? W'(2) : v + XONE;
  endfunction

  always_comb begin
    nx1       = x1;
    nx2       = x2;
    last_pair = 1'b0;
    if (x2 != XMAX) begin
      nx2 = step(x2);
    end else if (x1 == XMAX) begin
      last_pair = 1'b1;
    end else begin
      nx1 = step(x1);
`ifdef FACTOR_SEARCH_SYMM_EN
      nx2 = step(x1);
`else
      nx2 = '0;
`endif
    end
  end

  assign hit     = (acc == y_q) && (x1 != XONE) && (x2 != XONE);
  assign partial = x2[bit_cnt] ? ({{W{1'b0}}, x1} << bit_cnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      found     <= 1'b0;
      x1_out    <= '0;
      x2_out    <= '0;
      y_q       <= '0;
      acc       <= '0;
      x1        <= '0;
      x2        <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_q      <= y;
            x1       <= '0;
            x2       <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          acc <= acc + partial;
          if (bit_cnt == CW'(W - 1)) begin
            bit_cnt <= '0;
            state   <= CHK;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        CHK: begin
          if (hit) begin
            found     <= 1'b1;
            x1_out    <= x1;
            x2_out    <= x2;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (last_pair) begin
            found     <= 1'b0;
            x1_out    <= '0;
            x2_out    <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x1    <= nx1;
            x2    <= nx2;
            acc   <= '0;
            state <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factor_search_seq.sv
// Directed bench for factor_search_seq (W=2): vector table plus stall and mid-search reset sequences.
module tb_factor_search_seq;

  localparam int W = 2;
  localparam int BUDGET = 200;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] y = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           found;
  logic [W-1:0]   x1_out;
  logic [W-1:0]   x2_out;

  int checks = 0;
  int errors = 0;

  factor_search_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .found(found),
    .x1_out(x1_out), .x2_out(x2_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] y;
    logic       found;
    logic [1:0] x1;
    logic [1:0] x2;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive y for one rising edge; caller guarantees in_ready was high at the preceding negedge.
  task automatic accept(input logic [3:0] yv);
    in_valid = 1'b1;
    y        = yv;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the cycle count from the accept edge to the first cycle with out_valid high.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    check($sformatf("in_ready_before_y%0d", v.y), in_ready, 1);
    accept(v.y);
    wait_out(lat);
    check($sformatf("latency_y%0d", v.y), lat, v.lat);
    check($sformatf("found_y%0d", v.y), found, v.found);
    check($sformatf("x1_y%0d", v.y), x1_out, v.x1);
    check($sformatf("x2_y%0d", v.y), x2_out, v.x2);
    @(negedge clk);
    check($sformatf("out_valid_after_y%0d", v.y), out_valid, 0);
    check($sformatf("in_ready_after_y%0d", v.y), in_ready, 1);
  endtask

  initial begin
    vec_t v;
    int   lat;

`ifdef FACTOR_SEARCH_SYMM_EN
    vecs[0] = '{4'd6, 1'b1, 2'd2, 2'd3, 16};
    vecs[1] = '{4'd9, 1'b1, 2'd3, 2'd3, 19};
    vecs[2] = '{4'd5, 1'b0, 2'd0, 2'd0, 19};
    vecs[3] = '{4'd2, 1'b0, 2'd0, 2'd0, 19};
    vecs[4] = '{4'd0, 1'b1, 2'd0, 2'd0, 4};
    vecs[5] = '{4'd3, 1'b0, 2'd0, 2'd0, 19};
    vecs[6] = '{4'd4, 1'b1, 2'd2, 2'd2, 13};
    vecs[7] = '{4'd8, 1'b0, 2'd0, 2'd0, 19};
`else
    vecs[0] = '{4'd6, 1'b1, 2'd2, 2'd3, 19};
    vecs[1] = '{4'd9, 1'b1, 2'd3, 2'd3, 28};
    vecs[2] = '{4'd5, 1'b0, 2'd0, 2'd0, 28};
    vecs[3] = '{4'd2, 1'b0, 2'd0, 2'd0, 28};
    vecs[4] = '{4'd0, 1'b1, 2'd0, 2'd0, 4};
    vecs[5] = '{4'd3, 1'b0, 2'd0, 2'd0, 28};
    vecs[6] = '{4'd4, 1'b1, 2'd2, 2'd2, 16};
    vecs[7] = '{4'd8, 1'b0, 2'd0, 2'd0, 28};
`endif

    // Reset values while rst is held
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_found", found, 0);
    check("rst_x1", x1_out, 0);
    check("rst_x2", x2_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Output stall on y=4 with in_valid pulses that must be ignored
    out_ready = 1'b0;
    check("stall_in_ready_before", in_ready, 1);
    accept(4'd4);
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_found", found, 1);
      check("stall_x1", x1_out, 2);
      check("stall_x2", x2_out, 2);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1 begin
        in_valid = 1'b1;
        y        = 4'd9;
      end
      @(negedge clk);
    end
    // Release the stall with in_valid still high: it must not be taken on the transfer edge
    out_ready = 1'b1;
    check("release_found", found, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    @(negedge clk);
    check("release_no_accept", in_ready, 1);

    // Reset during MUL of y=9 aborts the search
    accept(4'd9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_found", found, 0);
    check("midrst_x1", x1_out, 0);
    check("midrst_x2", x2_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", out_valid, 0);
    v = '{4'd0, 1'b1, 2'd0, 2'd0, 4};
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
